// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet-5 sign-magnitude datapath.
// Data words: bit 15 = sign, bits 14:0 = magnitude; 0x8000 is treated as +0.
package lenet_pkg;

    localparam int          SM_W       = 16;
    localparam logic [14:0] SM_MAX_MAG = 15'h7FFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        BIAS = 2'd2,
        OUT  = 2'd3
    } acc_state_t;

    // Fold negative zero onto positive zero.
    function automatic logic [SM_W-1:0] sm_norm(input logic [SM_W-1:0] v);
        sm_norm = (v[SM_W-2:0] == '0) ? '0 : v;
    endfunction

endpackage

// File: rtl/conv_accum_sm_sat_add.sv
// sm_sat_add: combinational saturating sign-magnitude adder.
// Operands are widened to 17-bit two's complement, summed, clamped to a
// magnitude of 0x7FFF and converted back. A zero result is always 0x0000.
module sm_sat_add
    import lenet_pkg::*;
(
    input  logic [SM_W-1:0] a,
    input  logic [SM_W-1:0] b,
    output logic [SM_W-1:0] o,
    output logic            sat
);

    logic signed [SM_W:0] w_a;
    logic signed [SM_W:0] w_b;
    logic signed [SM_W:0] w_sum;
    logic        [SM_W:0] w_mag;
    logic        [14:0]   w_o_mag;

    // Widen, add, clamp and return to sign-magnitude.
    always_comb begin
        w_a = a[SM_W-1] ? -$signed({2'b00, a[SM_W-2:0]}) : $signed({2'b00, a[SM_W-2:0]});
        w_b = b[SM_W-1] ? -$signed({2'b00, b[SM_W-2:0]}) : $signed({2'b00, b[SM_W-2:0]});
        // |a|+|b| <= 0xFFFE, so the 17-bit sum cannot wrap.
        w_sum = w_a + w_b;
        w_mag = w_sum[SM_W] ? $unsigned(-w_sum) : $unsigned(w_sum);
        sat   = (w_mag > {2'b00, SM_MAX_MAG});
        w_o_mag = sat ? SM_MAX_MAG : w_mag[14:0];
        if (w_o_mag == '0) begin
            o = '0;
        end else begin
            o = {w_sum[SM_W], w_o_mag};
        end
    end

endmodule

// File: rtl/conv_accum.sv
// conv_accum: windowed sign-magnitude accumulator with per-window bias,
// feeding one result per window to the pooling stage over valid/ready.
// Optional build macro: CONV_ACCUM_RELU_EN clamps negative post-bias results
// to zero in the BIAS step (ovf still reports negative-side saturation).
//
// state | meaning
// IDLE  | waiting for the first term of a window; loads acc, bias, cnt
// ACC   | adding further terms until in_last or N_TERMS terms seen
// BIAS  | one cycle: acc += bias (then optional ReLU)
// OUT   | result presented; held until out_ready
module conv_accum
    import lenet_pkg::*;
#(
    parameter int N_TERMS = 25
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SM_W-1:0] in_data,
    input  logic            in_last,
    input  logic [SM_W-1:0] bias,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SM_W-1:0] out_data,
    output logic            ovf
);

    localparam int              CNT_W    = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);

    acc_state_t       r_state;
    acc_state_t       w_next;
    logic [SM_W-1:0]  r_acc;
    logic [SM_W-1:0]  r_bias_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    logic             w_rdy_st;
    logic             w_accept;
    logic [SM_W-1:0]  w_add_b;
    logic [SM_W-1:0]  w_add_o;
    logic             w_add_sat;
    logic [SM_W-1:0]  w_bias_res;

    // Single adder shared between term accumulation and the bias step.
    assign w_add_b = (r_state == BIAS) ? r_bias_q : in_data;

    sm_sat_add u_sat_add (
        .a   (r_acc),
        .b   (w_add_b),
        .o   (w_add_o),
        .sat (w_add_sat)
    );

`ifdef CONV_ACCUM_RELU_EN
    assign w_bias_res = w_add_o[SM_W-1] ? '0 : w_add_o;
`else
    assign w_bias_res = w_add_o;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (in_last || (N_TERMS == 1)) ? BIAS : ACC;
                end
            end
            ACC: begin
                if (w_accept) begin
                    w_next = (in_last || (r_cnt == CNT_LAST)) ? BIAS : ACC;
                end
            end
            BIAS: w_next = OUT;
            OUT: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state; in_ready is forced low during reset.
    always_comb begin
        w_rdy_st  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE:    w_rdy_st  = 1'b1;
            ACC:     w_rdy_st  = 1'b1;
            OUT:     out_valid = 1'b1;
            default: begin
                w_rdy_st  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    assign in_ready = w_rdy_st & rst_n;
    assign w_accept = in_valid & in_ready;
    assign out_data = r_acc;
    assign ovf      = r_ovf;

    // Accumulator, bias capture, term counter and sticky saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_bias_q <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_acc    <= sm_norm(in_data);
                        r_bias_q <= bias;
                        r_cnt    <= CNT_W'(1);
                        r_ovf    <= 1'b0;
                    end
                end
                ACC: begin
                    if (w_accept) begin
                        r_acc <= w_add_o;
                        r_cnt <= r_cnt + CNT_W'(1);
                        r_ovf <= r_ovf | w_add_sat;
                    end
                end
                BIAS: begin
                    r_acc <= w_bias_res;
                    r_ovf <= r_ovf | w_add_sat;
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_accum.sv
// Testbench for conv_accum: directed windows plus randomized windows checked
// against an integer reference of the accumulate/bias/saturate rules.
module tb_conv_accum;

    localparam int N = 25;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic [15:0] bias = 16'h0000;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        ovf;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] q_terms[$];

    conv_accum #(.N_TERMS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic int sm2i(input logic [15:0] v);
        return v[15] ? -int'(v[14:0]) : int'(v[14:0]);
    endfunction

    // Reference: integer running sum, clamp to +/-32767 after every addition.
    task automatic model(input logic [15:0] b, output logic [15:0] e, output logic eo);
        int s;
        eo = 1'b0;
        s = sm2i(q_terms[0]);
        for (int i = 1; i <= q_terms.size(); i++) begin
            s += (i == q_terms.size()) ? sm2i(b) : sm2i(q_terms[i]);
            if (s > 32767) begin s = 32767; eo = 1'b1; end
            if (s < -32767) begin s = -32767; eo = 1'b1; end
        end
`ifdef CONV_ACCUM_RELU_EN
        if (s < 0) s = 0;
`endif
        e = (s < 0) ? {1'b1, 15'(-s)} : {1'b0, 15'(s)};
    endtask

    // Feed q_terms as one window, then collect and check the result.
    task automatic send_window(input logic [15:0] b, input bit last_flag,
                               input int gaps, input int hold);
        logic [15:0] e;
        logic        eo;
        logic        ok;
        int          guard;
        model(b, e, eo);
        for (int i = 0; i < q_terms.size(); i++) begin
            if (gaps > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, gaps)) begin @(posedge clk); #1; end
            end
            in_valid = 1'b1;
            in_data  = q_terms[i];
            in_last  = last_flag && (i == q_terms.size() - 1);
            bias     = b;
            guard = 0;
            do begin
                ok = in_ready;
                @(posedge clk); #1;
                guard++;
            end while (!ok && guard < 50);
            if (!ok) begin
                chk("accept_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("closed_in_ready", in_ready, 0);
        chk("bias_out_valid", out_valid, 0);
        out_ready = (hold == 0);
        @(posedge clk); #1;
        chk("lat_out_valid", out_valid, 1);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, e);
            chk("hold_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        chk("out_data", out_data, e);
        chk("ovf", ovf, eo);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("post_hs_valid", out_valid, 0);
        chk("post_hs_ready", in_ready, 1);
    endtask

    task automatic fill(input int n, input logic [15:0] v);
        q_terms.delete();
        for (int i = 0; i < n; i++) q_terms.push_back(v);
    endtask

    // Accept n terms without closing the window (in_last only if asked).
    task automatic feed(input int n, input logic [15:0] v, input bit last_on_final);
        int guard;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = v;
            in_last  = last_on_final && (i == n - 1);
            guard = 0;
            while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 16'h0000);
        chk({tag, "_ovf"}, ovf, 0);
    endtask

    function automatic logic [15:0] rnd_word();
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        return {1'($urandom), 15'($urandom_range(0, 300))};
    endfunction

    initial begin
        #1;
        check_reset_vals("rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);
        @(posedge clk); #1;

        fill(25, 16'h0001);
        send_window(16'h8003, 1'b0, 0, 0);

        q_terms = '{16'h0005, 16'h800A, 16'h8000};
        send_window(16'h0002, 1'b1, 0, 0);

        fill(3, 16'h7000);
        send_window(16'h0000, 1'b1, 0, 0);
        fill(3, 16'hF000);
        send_window(16'h0000, 1'b1, 0, 0);

        q_terms = '{16'h0011, 16'h8002};
        send_window(16'h0001, 1'b1, 0, 10);
        q_terms = '{16'h0007};
        send_window(16'h0000, 1'b1, 0, 0);

        feed(7, 16'h0003, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        fill(25, 16'h0002);
        send_window(16'h0000, 1'b0, 0, 0);

        q_terms = '{16'h0004, 16'h8004};
        send_window(16'h8000, 1'b1, 0, 0);

        feed(1, 16'h7000, 1'b1);
        @(posedge clk); #1;
        chk("pre_rst_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("out_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;

        for (int w = 0; w < 40; w++) begin
            int  len;
            bit  lf;
            len = $urandom_range(1, N);
            lf  = (len < N) ? 1'b1 : 1'($urandom);
            q_terms.delete();
            for (int i = 0; i < len; i++) q_terms.push_back(rnd_word());
            send_window(rnd_word(), lf, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_accum.md
# conv_accum

Sequential sign-magnitude accumulator that sits directly downstream of the 16-bit sign-magnitude adder/multiplier path in the LeNet-5 convolution datapath. It sums a window of N_TERMS signed products, adds a per-channel bias, optionally applies ReLU, and hands one result per window to the pooling stage over a valid/ready handshake. All data words use the datapath format: bit 15 = sign, bits 14:0 = magnitude. Negative zero (0x8000) is treated as +0.

## Interface
- N_TERMS, 25: terms per window (5x5 kernel). Legal range is 1..1024.
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  product word valid
- in_ready  out  1  block can accept a product this cycle
- in_data  in  16  sign-magnitude product
- in_last  in  1  marks the final term of a short window
- bias  in  16  sign-magnitude bias, sampled when the first term of a window is accepted
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  16  sign-magnitude result
- ovf  out  1  sticky for the current window: saturation occurred; valid with out_valid

## Operation
- The state machine has four states: IDLE, ACC, BIAS, OUT. Reset enters IDLE.
- in_ready = 1 in IDLE and ACC. in_ready = 0 in BIAS and OUT.
- IDLE, on accept:
  - acc = normalised in_data (0x8000 becomes 0x0000).
  - bias_q = bias; cnt = 1; ovf = 0.
  - If in_last = 1 or N_TERMS = 1, go to BIAS. Otherwise go to ACC.
- ACC, on accept:
  - acc = sat_add(acc, in_data); cnt++.
  - If in_last = 1 or cnt+1 = N_TERMS, go to BIAS.
  - If in_valid = 0, the state holds with no change.
- BIAS: acc = sat_add(acc, bias_q), then go to OUT. This takes exactly one cycle.
- OUT: out_valid = 1. out_data and ovf are stable until out_ready = 1. On the handshake, go to IDLE.
- sat_add arithmetic:
  - Convert both operands to 17-bit two's complement and add.
  - If |sum| > 0x7FFF, clamp the magnitude to 0x7FFF, keep the sign, and set ovf.
  - Convert the result back to sign-magnitude. A zero result is always 0x0000, never 0x8000.
- in_last in IDLE produces a 1-term window. A term that arrives while in_ready = 0 is not consumed; upstream must hold it.
- rst_n low at any point, including mid-window or with out_valid high, aborts the window. Partial sums are discarded.

## Timing
- Reset values: in_ready = 0 while rst_n = 0, and 1 in the first IDLE cycle after release. out_valid = 0, out_data = 0x0000, ovf = 0. Internally, acc = 0, cnt = 0, bias_q = 0.
- Last term accepted at edge t: BIAS in cycle t+1, out_valid = 1 from edge t+2.
- A full window with continuous in_valid takes N_TERMS + 2 cycles to the first out_valid.
- Back-to-back windows: the first term of the next window can be accepted in the cycle after the out handshake, because IDLE is entered on that edge. There is a 3-cycle bubble per window when out_ready is held at 1.
- out_valid is not withdrawn before out_ready = 1, and out_data does not change while out_valid = 1 and out_ready = 0.
- The cnt width is $clog2(N_TERMS+1).

## Configuration
- CONV_ACCUM_RELU_EN defined:
  - In the BIAS state, a negative post-bias result is replaced by 0x0000.
  - ovf is still set if the saturation came from the negative side.
- CONV_ACCUM_RELU_EN undefined: the signed result is passed through unchanged.

## Structure
- The shared package lenet_pkg holds:
  - the SM_W = 16 data width constant,
  - the SM_MAX_MAG = 15'h7FFF constant,
  - the state-encoding typedef (IDLE/ACC/BIAS/OUT).
- One combinational sub-module, sm_sat_add, contains the saturating sign-magnitude add. It has inputs a[15:0], b[15:0] and outputs o[15:0], sat.
- sm_sat_add is instantiated once and muxed between the in_data and bias_q operands. Everything else lives in conv_accum.

## Test plan
- Full window, N_TERMS = 25, with terms 0x0001 ×25 and bias 0x8003 (-3): out_data = 0x0016 (22), ovf = 0. out_valid rises exactly 2 cycles after the 25th accept.
- Mixed signs with in_last on the 3rd term: 0x0005, 0x800A, 0x8000, bias 0x0002.
  - Without RELU_EN: out_data = 0x8003.
  - With RELU_EN: out_data = 0x0000.
  - In both cases the window closes after 3 terms.
- Saturation: terms 0x7000 ×3 with bias 0, in_last on term 3: out_data = 0x7FFF, ovf = 1. Then a negative mirror window (0xF000 ×3): out_data = 0xFFFF, ovf = 1.
- Backpressure: out_ready held at 0 for 10 cycles with in_valid held at 1. Required: in_ready = 0 throughout; out_data stable; the next window's first term is accepted in the cycle after out_ready = 1.
- Reset mid-window: assert rst_n = 0 after 7 terms. Required: all outputs return to their reset values immediately; the next full window of 0x0002 ×25 with bias 0 gives 0x0032.
- Cancellation to zero: terms 0x0004, 0x8004 with in_last and bias 0x8000: out_data = 0x0000, never 0x8000.
